// File: rtl/mfp_seven_segment_scanner.sv
// Time-multiplexed seven-segment scanner: blanking gap between digits, shadow copy of the inputs taken once per frame.
// Optional build macro MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits at shadow load.
module mfp_seven_segment_scanner #(
  parameter int N_DIGITS         = 8,
  parameter int CLK_DIV          = 50000,
  parameter int BLANK_CYCLES     = 64,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [4*N_DIGITS-1:0]   hex_data,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic [N_DIGITS-1:0]     anodes,
  output logic [6:0]              segments,
  output logic                    seg_dp,
  output logic                    frame_start
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int PW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0]       SHOW_TC  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]       BLANK_TC = PW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]       IDX_TC   = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF   = (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state_r, state_next_s;
  logic [PW-1:0]           presc_r, presc_next_s;
  logic [IW-1:0]           idx_r, idx_next_s;
  logic                    load_s;
  logic [4*N_DIGITS-1:0]   hex_sh_r;
  logic [N_DIGITS-1:0]     dp_sh_r;
  logic [N_DIGITS-1:0]     en_sh_r;
  logic [N_DIGITS-1:0]     en_load_s;
  logic [3:0]              sel_nib_s;
  logic                    sel_en_s;
  logic                    sel_dp_s;
  logic [N_DIGITS-1:0]     an_on_s;
  logic [6:0]              seg_on_s;
  logic                    dp_on_s;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'h3F;
      4'h1:    seg_decode = 7'h06;
      4'h2:    seg_decode = 7'h5B;
      4'h3:    seg_decode = 7'h4F;
      4'h4:    seg_decode = 7'h66;
      4'h5:    seg_decode = 7'h6D;
      4'h6:    seg_decode = 7'h7D;
      4'h7:    seg_decode = 7'h07;
      4'h8:    seg_decode = 7'h7F;
      4'h9:    seg_decode = 7'h6F;
      4'hA:    seg_decode = 7'h77;
      4'hB:    seg_decode = 7'h7C;
      4'hC:    seg_decode = 7'h39;
      4'hD:    seg_decode = 7'h5E;
      4'hE:    seg_decode = 7'h79;
      4'hF:    seg_decode = 7'h71;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // A frame begins on the first BLANK cycle in front of digit 0.
  assign load_s = (state_r == ST_BLANK) && (presc_r == '0) && (idx_r == '0);

`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Keep every digit at or below the highest non-zero nibble or lit decimal point; digit 0 is always kept.
  always_comb begin
    logic keep_v;
    keep_v    = 1'b0;
    en_load_s = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      keep_v       = keep_v | (hex_data[4*k +: 4] != 4'h0) | dp_in[k];
      en_load_s[k] = digit_en[k] & keep_v;
    end
    en_load_s[0] = digit_en[0];
  end
`else
  assign en_load_s = digit_en;
`endif

  // Scan state, prescaler and digit index.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_BLANK;
      presc_r <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_next_s;
      presc_r <= presc_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Next-state logic: BLANK_CYCLES of blanking, then CLK_DIV of SHOW, then advance to the next digit.
  always_comb begin
    state_next_s = state_r;
    presc_next_s = presc_r + PW'(1);
    idx_next_s   = idx_r;
    case (state_r)
      ST_BLANK: begin
        if (presc_r == BLANK_TC) begin
          state_next_s = ST_SHOW;
          presc_next_s = '0;
        end else begin
          state_next_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (presc_r == SHOW_TC) begin
          state_next_s = ST_BLANK;
          presc_next_s = '0;
          idx_next_s   = (idx_r == IDX_TC) ? '0 : idx_r + IW'(1);
        end else begin
          state_next_s = ST_SHOW;
        end
      end
      default: begin
        state_next_s = ST_BLANK;
        presc_next_s = '0;
        idx_next_s   = '0;
      end
    endcase
  end

  // Frame-coherent shadow copy of the display inputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hex_sh_r <= '0;
      dp_sh_r  <= '0;
      en_sh_r  <= '0;
    end else if (load_s) begin
      hex_sh_r <= hex_data;
      dp_sh_r  <= dp_in;
      en_sh_r  <= en_load_s;
    end else begin
      hex_sh_r <= hex_sh_r;
      dp_sh_r  <= dp_sh_r;
      en_sh_r  <= en_sh_r;
    end
  end

  // Select the current digit's shadow fields and form active-high drive levels.
  always_comb begin
    sel_nib_s = 4'h0;
    sel_en_s  = 1'b0;
    sel_dp_s  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      sel_nib_s = sel_nib_s | (hex_sh_r[4*k +: 4] & {4{idx_r == IW'(k)}});
      sel_en_s  = sel_en_s  | (en_sh_r[k] & (idx_r == IW'(k)));
      sel_dp_s  = sel_dp_s  | (dp_sh_r[k] & (idx_r == IW'(k)));
    end
    if ((state_r == ST_SHOW) && sel_en_s) begin
      an_on_s  = N_DIGITS'(1) << idx_r;
      seg_on_s = seg_decode(sel_nib_s);
      dp_on_s  = sel_dp_s;
    end else begin
      an_on_s  = '0;
      seg_on_s = 7'h00;
      dp_on_s  = 1'b0;
    end
  end

  // Registered pad drive; XOR with the off level applies the configured polarity.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      anodes      <= AN_OFF;
      segments    <= SEG_OFF;
      seg_dp      <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      anodes      <= an_on_s ^ AN_OFF;
      segments    <= seg_on_s ^ SEG_OFF;
      seg_dp      <= dp_on_s ^ DP_OFF;
      frame_start <= load_s;
    end
  end

endmodule

// File: tb/tb_mfp_seven_segment_scanner.sv
// Self-checking bench for mfp_seven_segment_scanner (N_DIGITS=8, CLK_DIV=4, BLANK_CYCLES=2, active-low).
module tb_mfp_seven_segment_scanner;

  localparam int N     = 8;
  localparam int CD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = CD + BC;
  localparam int FRAME = N * SLOT;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] hex_data;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        seg_dp;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int c      = 0;
  int pos    = 0;

  logic [31:0] sh_hex = 32'h0;
  logic [7:0]  sh_dp  = 8'h0;
  logic [7:0]  sh_en  = 8'h0;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fs;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  mfp_seven_segment_scanner #(
    .N_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BC), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hex_data(hex_data), .dp_in(dp_in), .digit_en(digit_en),
    .anodes(anodes), .segments(segments), .seg_dp(seg_dp), .frame_start(frame_start)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: cycle c after reset release sits at position c mod FRAME of a frame;
  // each digit owns SLOT cycles, the first BC of which are blank.
  task automatic step();
    int d;
    int top;
    @(posedge HCLK);
    #1;
    pos = c % FRAME;
    if (pos == 0) begin
      sh_hex = hex_data;
      sh_dp  = dp_in;
      sh_en  = digit_en;
`ifdef MFP_SEVEN_SEG_LEADING_ZERO_BLANK_EN
      top = 0;
      for (int k = 0; k < N; k++)
        if (sh_hex[4*k +: 4] != 4'h0 || sh_dp[k]) top = k;
      for (int k = 0; k < N; k++)
        if (k > top) sh_en[k] = 1'b0;
`else
      top = 0;
`endif
    end
    d = pos / SLOT;
    if ((pos % SLOT) >= BC && sh_en[d]) begin
      exp_an  = ~(8'b1 << d);
      exp_seg = ~seg_tab[sh_hex[4*d +: 4]];
      exp_dp  = ~sh_dp[d];
    end else begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end
    exp_fs = (pos == 0);
    c++;
  endtask

  task automatic align();
    while (c % FRAME != 0) step();
  endtask

  task automatic test_reset();
    HRESETn  = 1'b0;
    hex_data = 32'h0;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    repeat (3) @(posedge HCLK);
    #1;
    checks++; if (anodes !== 8'hFF) begin errors++; $display("FAIL reset_anodes: got %h want %h", anodes, 8'hFF); end
    checks++; if (segments !== 7'h7F) begin errors++; $display("FAIL reset_segments: got %h want %h", segments, 7'h7F); end
    checks++; if (seg_dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", seg_dp); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    c = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      checks++; if (anodes !== exp_an) begin errors++; $display("FAIL post_reset_anodes c=%0d: got %h want %h", pos, anodes, exp_an); end
      checks++; if (frame_start !== exp_fs) begin errors++; $display("FAIL post_reset_fs c=%0d: got %b want %b", pos, frame_start, exp_fs); end
      if (pos >= 2 && pos < 6) begin
        checks++; if (segments !== 7'h40) begin errors++; $display("FAIL post_reset_zero c=%0d: got %h want 40", pos, segments); end
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] fixed [8] = '{~7'h71, ~7'h79, ~7'h5E, ~7'h39, ~7'h7C, ~7'h77, ~7'h6F, ~7'h7F};
    hex_data = 32'h89AB_CDEF;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    align();
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (anodes !== exp_an) begin errors++; $display("FAIL scan_anodes pos=%0d: got %h want %h", pos, anodes, exp_an); end
      checks++; if (frame_start !== exp_fs) begin errors++; $display("FAIL scan_fs pos=%0d: got %b want %b", pos, frame_start, exp_fs); end
      if (pos % SLOT >= BC) begin
        checks++; if (segments !== fixed[pos / SLOT]) begin errors++; $display("FAIL scan_fixed_seg pos=%0d: got %h want %h", pos, segments, fixed[pos / SLOT]); end
      end
    end
    repeat (4) begin
      hex_data = $urandom;
      dp_in    = 8'($urandom);
      digit_en = 8'($urandom);
      for (int i = 0; i < FRAME + int'($urandom_range(0, 20)); i++) begin
        step();
        checks++; if (anodes !== exp_an) begin errors++; $display("FAIL rand_anodes pos=%0d: got %h want %h", pos, anodes, exp_an); end
        checks++; if (segments !== exp_seg) begin errors++; $display("FAIL rand_segments pos=%0d: got %h want %h", pos, segments, exp_seg); end
        checks++; if (seg_dp !== exp_dp) begin errors++; $display("FAIL rand_dp pos=%0d: got %b want %b", pos, seg_dp, exp_dp); end
        checks++; if (frame_start !== exp_fs) begin errors++; $display("FAIL rand_fs pos=%0d: got %b want %b", pos, frame_start, exp_fs); end
        checks++; if ($countones(~anodes) > 1) begin errors++; $display("FAIL rand_onehot pos=%0d: got %h want at most one low", pos, anodes); end
        if (i == 17) begin
          hex_data = $urandom;
          dp_in    = 8'($urandom);
        end
      end
    end
  endtask

  task automatic test_update();
    int fr;
    logic [6:0] want;
    hex_data = 32'h1;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    align();
    fr = 0;
    for (int i = 0; i < FRAME + SLOT; i++) begin
      step();
      if (pos == 0) fr++;
      if (pos % SLOT >= BC && pos / SLOT == 0) begin
        want = (fr == 1) ? 7'h79 : 7'h24;
        checks++; if (segments !== want) begin errors++; $display("FAIL update_digit0 frame=%0d pos=%0d: got %h want %h", fr, pos, segments, want); end
      end
      checks++; if (segments !== exp_seg) begin errors++; $display("FAIL update_segments pos=%0d: got %h want %h", pos, segments, exp_seg); end
      if (pos == 3 * SLOT + BC) hex_data = 32'h2;
    end
  endtask

  task automatic test_enable_dp();
    logic want_dp;
    hex_data = $urandom;
    dp_in    = 8'h04;
    digit_en = 8'h05;
    align();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      want_dp = !((pos / SLOT == 2) && (pos % SLOT >= BC));
      checks++; if (anodes !== exp_an) begin errors++; $display("FAIL en_anodes pos=%0d: got %h want %h", pos, anodes, exp_an); end
      checks++; if ((~anodes & 8'hFA) !== 8'h00) begin errors++; $display("FAIL en_disabled_lit pos=%0d: got %h want bits 0,2 only", pos, anodes); end
      checks++; if (seg_dp !== want_dp) begin errors++; $display("FAIL en_dp pos=%0d: got %b want %b", pos, seg_dp, want_dp); end
      checks++; if (frame_start !== (pos == 0)) begin errors++; $display("FAIL en_fs pos=%0d: got %b want %b", pos, frame_start, pos == 0); end
    end
  endtask

  task automatic test_async_reset();
    hex_data = $urandom;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    align();
    do step(); while (pos != 5 * SLOT + BC + 1);
    checks++; if (anodes !== 8'hDF) begin errors++; $display("FAIL arst_pre_anodes: got %h want DF", anodes); end
    #1;
    HRESETn = 1'b0;
    #1;
    checks++; if (anodes !== 8'hFF) begin errors++; $display("FAIL arst_anodes: got %h want FF", anodes); end
    checks++; if (segments !== 7'h7F) begin errors++; $display("FAIL arst_segments: got %h want 7F", segments); end
    checks++; if (seg_dp !== 1'b1) begin errors++; $display("FAIL arst_dp: got %b want 1", seg_dp); end
    @(posedge HCLK);
    #1;
    checks++; if (anodes !== 8'hFF) begin errors++; $display("FAIL arst_hold_anodes: got %h want FF", anodes); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    c = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (anodes !== exp_an) begin errors++; $display("FAIL arst_restart_anodes pos=%0d: got %h want %h", pos, anodes, exp_an); end
      checks++; if (frame_start !== exp_fs) begin errors++; $display("FAIL arst_restart_fs pos=%0d: got %b want %b", pos, frame_start, exp_fs); end
      if (pos == 2) begin
        checks++; if (anodes !== 8'hFE) begin errors++; $display("FAIL arst_digit0_start: got %h want FE", anodes); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_update();
    test_enable_dp();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
